// File: rtl/fetch_queue_pkg.sv
// Shared front-end definitions: default geometry and the fetch-packet layout.
package fetch_queue_pkg;

  // Default number of fetch-packet entries (power of two, >= 2).
  localparam int unsigned FqDepth = 8;
  // Default PC / instruction-slot width.
  localparam int unsigned FqXlen  = 32;

  // One fetch packet as stored in the queue; pc sits in the LSBs.
  typedef struct packed {
    logic                  pred_taken;
    logic [1:0]            mask;
    logic [2*FqXlen-1:0]   insts;
    logic [FqXlen-1:0]     pc;
  } fetch_packet_t;

  localparam int unsigned FetchPacketW = $bits(fetch_packet_t);

  // Advance a wrap-bit pointer by one; the carry into the MSB toggles the wrap bit.
  function automatic logic [$clog2(FqDepth):0] ptr_inc(input logic [$clog2(FqDepth):0] ptr);
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module fetch_queue_ram #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 99
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write the addressed entry on an enqueue.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Head fields come straight from the array; no output register.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between stage-2 fetch and decode: circular buffer of fetch packets
// with wrap-bit head/tail pointers, registered full flag and single-cycle flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FqDepth,
  parameter int unsigned XLEN  = FqXlen
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_i_enq_valid,
  input  logic [XLEN-1:0]          io_i_enq_pc,
  input  logic [2*XLEN-1:0]        io_i_enq_insts,
  input  logic [1:0]               io_i_enq_mask,
  input  logic                     io_i_enq_pred_taken,
  input  logic                     io_i_flush,
  input  logic                     io_i_deq_ready,
  output logic                     io_o_deq_valid,
  output logic [XLEN-1:0]          io_o_deq_pc,
  output logic [2*XLEN-1:0]        io_o_deq_insts,
  output logic [1:0]               io_o_deq_mask,
  output logic                     io_o_deq_pred_taken,
  output logic                     io_o_full,
  output logic [$clog2(DEPTH):0]   io_o_count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic            full_q, full_d;

  logic            enq_fire;
  logic            deq_fire;
  logic            not_empty;
  logic [PtrW-1:0] count_d;

  fetch_packet_t   wr_pkt;
  fetch_packet_t   rd_pkt;

  // Occupancy is the pointer distance; wrap bits make DEPTH representable.
  assign io_o_count = tail_q - head_q;
  assign not_empty  = (tail_q != head_q);

  // Full uses the registered flag only, so a same-cycle dequeue cannot admit an enqueue.
  assign enq_fire       = io_i_enq_valid & ~full_q & ~io_i_flush;
  assign io_o_deq_valid = not_empty & ~io_i_flush;
  assign deq_fire       = io_o_deq_valid & io_i_deq_ready;
  assign io_o_full      = full_q;

  // Pack the incoming fields into the shared packet layout.
  always_comb begin
    wr_pkt            = '0;
    wr_pkt.pc         = io_i_enq_pc;
    wr_pkt.insts      = io_i_enq_insts;
    wr_pkt.mask       = io_i_enq_mask;
    wr_pkt.pred_taken = io_i_enq_pred_taken;
  end

  fetch_queue_ram #(
    .Depth (DEPTH),
    .Width (FetchPacketW)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (enq_fire),
    .waddr_i (tail_q[AddrW-1:0]),
    .wdata_i (wr_pkt),
    .raddr_i (head_q[AddrW-1:0]),
    .rdata_o (rd_pkt)
  );

  // Unpack the head entry onto the dequeue port.
  always_comb begin
    io_o_deq_pc         = rd_pkt.pc;
    io_o_deq_insts      = rd_pkt.insts;
    io_o_deq_mask       = rd_pkt.mask;
    io_o_deq_pred_taken = rd_pkt.pred_taken;
  end

  // Next pointers and full flag; flush overrides any enqueue or dequeue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = '0;
    full_d  = 1'b0;
    if (io_i_flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq_fire) begin
        tail_d = ptr_inc(tail_q);
      end
      if (deq_fire) begin
        head_d = ptr_inc(head_q);
      end
    end
    count_d = tail_d - head_d;
    full_d  = (count_d == PtrW'(DEPTH));
  end

  // Pointer and full-flag state; reset clears occupancy but never the storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      full_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      full_q <= full_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/full, refused enqueue, steady-state wrap,
// flush priority, no-bypass latency and asynchronous reset.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_i_enq_valid;
  logic [31:0] io_i_enq_pc;
  logic [63:0] io_i_enq_insts;
  logic [1:0]  io_i_enq_mask;
  logic        io_i_enq_pred_taken;
  logic        io_i_flush;
  logic        io_i_deq_ready;
  logic        io_o_deq_valid;
  logic [31:0] io_o_deq_pc;
  logic [63:0] io_o_deq_insts;
  logic [1:0]  io_o_deq_mask;
  logic        io_o_deq_pred_taken;
  logic        io_o_full;
  logic [3:0]  io_o_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] next_pc;

  fetch_queue #(
    .DEPTH (8),
    .XLEN  (32)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .io_i_enq_valid      (io_i_enq_valid),
    .io_i_enq_pc         (io_i_enq_pc),
    .io_i_enq_insts      (io_i_enq_insts),
    .io_i_enq_mask       (io_i_enq_mask),
    .io_i_enq_pred_taken (io_i_enq_pred_taken),
    .io_i_flush          (io_i_flush),
    .io_i_deq_ready      (io_i_deq_ready),
    .io_o_deq_valid      (io_o_deq_valid),
    .io_o_deq_pc         (io_o_deq_pc),
    .io_o_deq_insts      (io_o_deq_insts),
    .io_o_deq_mask       (io_o_deq_mask),
    .io_o_deq_pred_taken (io_o_deq_pred_taken),
    .io_o_full           (io_o_full),
    .io_o_count          (io_o_count)
  );

  always #5 clock = ~clock;

  // Packet contents are derived from the pc so the head can be checked field by field.
  function automatic logic [63:0] insts_of(input logic [31:0] pc);
    return {~pc, pc ^ 32'h0000_0013};
  endfunction
  function automatic logic [1:0] mask_of(input logic [31:0] pc);
    return {pc[2], 1'b1};
  endfunction
  function automatic logic pred_of(input logic [31:0] pc);
    return pc[4];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_pc"},    {32'h0, io_o_deq_pc}, {32'h0, pc});
    check({tag, "_insts"}, io_o_deq_insts, insts_of(pc));
    check({tag, "_mask"},  {62'h0, io_o_deq_mask}, {62'h0, mask_of(pc)});
    check({tag, "_pred"},  {63'h0, io_o_deq_pred_taken}, {63'h0, pred_of(pc)});
  endtask

  task automatic drive_enq(input logic [31:0] pc);
    io_i_enq_valid      = 1'b1;
    io_i_enq_pc         = pc;
    io_i_enq_insts      = insts_of(pc);
    io_i_enq_mask       = mask_of(pc);
    io_i_enq_pred_taken = pred_of(pc);
  endtask

  task automatic idle();
    io_i_enq_valid = 1'b0;
    io_i_deq_ready = 1'b0;
    io_i_flush     = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    io_i_enq_valid      = 1'b0;
    io_i_enq_pc         = '0;
    io_i_enq_insts      = '0;
    io_i_enq_mask       = '0;
    io_i_enq_pred_taken = 1'b0;
    io_i_flush          = 1'b0;
    io_i_deq_ready      = 1'b0;

    // Reset state
    #12;
    check("rst_full",  {63'h0, io_o_full}, 64'd0);
    check("rst_valid", {63'h0, io_o_deq_valid}, 64'd0);
    check("rst_count", {60'h0, io_o_count}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // No bypass: enqueue into empty queue is visible only next cycle
    drive_enq(32'h0000_0500);
    #1;
    check("nobyp_same_cycle_valid", {63'h0, io_o_deq_valid}, 64'd0);
    tick();
    idle();
    check("nobyp_next_valid", {63'h0, io_o_deq_valid}, 64'd1);
    check("nobyp_next_count", {60'h0, io_o_count}, 64'd1);
    check_head("nobyp_head", 32'h0000_0500);
    io_i_deq_ready = 1'b1;
    tick();
    idle();
    check("nobyp_drained_count", {60'h0, io_o_count}, 64'd0);
    check("nobyp_drained_valid", {63'h0, io_o_deq_valid}, 64'd0);

    // Dequeue attempt on empty queue must not underflow
    io_i_deq_ready = 1'b1;
    tick();
    idle();
    check("underflow_count", {60'h0, io_o_count}, 64'd0);

    // Fill to DEPTH with deq_ready low
    for (int i = 0; i < 8; i++) begin
      drive_enq(32'h1000 + 32'(8 * i));
      #1;
      if (i == 7) begin
        check("fill7_full",  {63'h0, io_o_full}, 64'd0);
        check("fill7_count", {60'h0, io_o_count}, 64'd7);
      end
      tick();
    end
    idle();
    check("fill8_full",  {63'h0, io_o_full}, 64'd1);
    check("fill8_count", {60'h0, io_o_count}, 64'd8);

    // Ninth packet while full is ignored
    drive_enq(32'h0000_dead);
    tick();
    idle();
    check("ovf_count", {60'h0, io_o_count}, 64'd8);
    check("ovf_full",  {63'h0, io_o_full}, 64'd1);
    check_head("ovf_head", 32'h0000_1000);

    // Full queue with enq and deq together: only the dequeue happens
    drive_enq(32'h0000_beef);
    io_i_deq_ready = 1'b1;
    #1;
    check("fulldeq_valid", {63'h0, io_o_deq_valid}, 64'd1);
    check("fulldeq_pc", {32'h0, io_o_deq_pc}, 64'h1000);
    tick();
    idle();
    check("fulldeq_count", {60'h0, io_o_count}, 64'd7);
    check("fulldeq_full",  {63'h0, io_o_full}, 64'd0);

    // Drain the rest in order; neither refused packet may appear
    io_i_deq_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      #1;
      check("drain_pc", {32'h0, io_o_deq_pc}, 64'(32'h1000 + 32'(8 * i)));
      tick();
    end
    idle();
    check("drain_count", {60'h0, io_o_count}, 64'd0);
    check("drain_valid", {63'h0, io_o_deq_valid}, 64'd0);

    // Three entries, then 20 cycles of simultaneous enq/deq across the wrap
    for (int i = 0; i < 3; i++) begin
      drive_enq(32'h2000 + 32'(4 * i));
      exp_q.push_back(32'h2000 + 32'(4 * i));
      tick();
    end
    next_pc = 32'h200c;
    for (int c = 0; c < 20; c++) begin
      drive_enq(next_pc);
      io_i_deq_ready = 1'b1;
      #1;
      check("steady_count", {60'h0, io_o_count}, 64'd3);
      check("steady_pc", {32'h0, io_o_deq_pc}, {32'h0, exp_q[0]});
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
    end
    idle();
    check("steady_end_count", {60'h0, io_o_count}, 64'd3);
    check_head("steady_end_head", exp_q[0]);

    // Grow to five entries, then flush with enq and deq both requested
    for (int i = 0; i < 2; i++) begin
      drive_enq(next_pc);
      next_pc = next_pc + 32'd4;
      tick();
    end
    idle();
    check("preflush_count", {60'h0, io_o_count}, 64'd5);
    drive_enq(32'h0000_3333);
    io_i_deq_ready = 1'b1;
    io_i_flush     = 1'b1;
    #1;
    check("flush_deq_valid", {63'h0, io_o_deq_valid}, 64'd0);
    tick();
    idle();
    check("postflush_count", {60'h0, io_o_count}, 64'd0);
    check("postflush_full",  {63'h0, io_o_full}, 64'd0);
    check("postflush_valid", {63'h0, io_o_deq_valid}, 64'd0);
    drive_enq(32'h0000_3000);
    tick();
    idle();
    check("afterflush_count", {60'h0, io_o_count}, 64'd1);
    check_head("afterflush_head", 32'h0000_3000);
    io_i_deq_ready = 1'b1;
    tick();
    idle();

    // Asynchronous reset between edges with four entries held
    for (int i = 0; i < 4; i++) begin
      drive_enq(32'h4000 + 32'(4 * i));
      tick();
    end
    idle();
    check("prereset_count", {60'h0, io_o_count}, 64'd4);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_count", {60'h0, io_o_count}, 64'd0);
    check("async_rst_full",  {63'h0, io_o_full}, 64'd0);
    check("async_rst_valid", {63'h0, io_o_deq_valid}, 64'd0);
    #2;
    reset = 1'b1;
    tick();
    drive_enq(32'h0000_5000);
    tick();
    idle();
    check("postrst_count", {60'h0, io_o_count}, 64'd1);
    check("postrst_valid", {63'h0, io_o_deq_valid}, 64'd1);
    check_head("postrst_head", 32'h0000_5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, 8, number of fetch-packet entries; a power of two, at least 2.
REQ-002 Parameter: XLEN, 32, width of the PC and of each instruction slot.
REQ-003 Port: clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: io_i_enq_valid  in  1  stage-2 fetch packet present this cycle.
REQ-006 Port: io_i_enq_pc  in  XLEN  PC of slot 0 of the packet.
REQ-007 Port: io_i_enq_insts  in  2*XLEN  two instruction slots; slot 0 in the LSBs.
REQ-008 Port: io_i_enq_mask  in  2  per-slot valid bits.
REQ-009 Port: io_i_enq_pred_taken  in  1  packet carries a predicted-taken branch.
REQ-010 Port: io_i_flush  in  1  fetch-queue flush, driven by front-end control.
REQ-011 Port: io_i_deq_ready  in  1  decode accepts the head packet.
REQ-012 Port: io_o_deq_valid  out  1  head packet is valid.
REQ-013 Port: io_o_deq_pc / io_o_deq_insts / io_o_deq_mask / io_o_deq_pred_taken  out  XLEN / 2*XLEN / 2 / 1  head packet fields.
REQ-014 Port: io_o_full  out  1  queue full; feeds the stage-2 stall of front-end control.
REQ-015 Port: io_o_count  out  log2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Storage SHALL be a circular buffer with head and tail pointers of log2(DEPTH) bits plus one wrap bit each.
REQ-017 io_o_full SHALL be 1 exactly when count == DEPTH; it SHALL be a registered value with no combinational path from any input.
REQ-018 Enqueue SHALL occur iff io_i_enq_valid & ~io_o_full & ~io_i_flush; it writes at the tail, and the tail then advances by 1.
REQ-019 When io_i_enq_valid is 1 while full, the packet SHALL NOT be written and no state SHALL change; front-end control holds the packet upstream.
REQ-020 io_o_deq_valid SHALL equal (count != 0) & ~io_i_flush.
REQ-021 Dequeue SHALL occur iff io_o_deq_valid & io_i_deq_ready; the head then advances by 1.
REQ-022 The head fields SHALL be driven directly from the entry at the head pointer; there is no output register.
REQ-023 There is no bypass: a packet enqueued in cycle N SHALL first appear at the head no earlier than cycle N+1.
REQ-024 Full is evaluated from the current count, so an enqueue is refused when the queue is full even if a dequeue occurs in the same cycle.
REQ-025 Simultaneous enqueue and dequeue with count between 1 and DEPTH-1 SHALL leave count unchanged.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 and toggle their wrap bit on wrap.
REQ-027 io_i_flush SHALL take priority over all other inputs: in the next cycle head = tail = 0 and count = 0.
REQ-028 During a flush cycle, enqueue and dequeue SHALL both be suppressed.
REQ-029 io_o_count SHALL never exceed DEPTH and SHALL never underflow.

Reset
REQ-030 Assertion of reset (0) SHALL immediately clear head, tail and count, giving io_o_full = 0, io_o_deq_valid = 0 and io_o_count = 0, regardless of clock.
REQ-031 Entry storage SHALL NOT be reset; head fields are don't-care while io_o_deq_valid is 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries; the first enqueue after deassertion SHALL land in entry 0.

Structure
REQ-033 DEPTH, XLEN and the packed fetch-packet type (pc, insts, mask, pred_taken) SHALL live in the shared front-end package.
REQ-034 The storage array SHALL be one sub-module, fetch_queue_ram: one write port and one asynchronous read port, with no reset.

Verification
REQ-035 Scenario: after reset, enqueue 8 packets with pc = 0x1000 + 8*i and deq_ready = 0 -> io_o_full = 1 and io_o_count = 8 one cycle after the 8th; a 9th enq_valid is ignored.
REQ-036 Scenario: full queue, enq_valid = 1 and deq_ready = 1 for one cycle -> head pc 0x1000 leaves, no enqueue occurs, count = 7.
REQ-037 Scenario: 3 entries, enq_valid = deq_ready = 1 for 20 cycles -> count stays 3, wrap occurs, and PCs emerge in FIFO order.
REQ-038 Scenario: 5 entries, flush together with enq_valid and deq_ready -> deq_valid = 0 in that cycle; next cycle count = 0 and full = 0, and the packet is not stored.
REQ-039 Scenario: enqueue in cycle N into an empty queue -> deq_valid = 0 in cycle N and 1 in cycle N+1 with matching fields.
REQ-040 Scenario: reset pulsed low between clock edges with 4 entries held -> outputs clear immediately; after release, the first packet appears at the head unchanged.
